// File: rtl/kbd_pkg.sv
// kbd_pkg: shared prefix-tracking states and PS/2 set-2 scancode constants.
package kbd_pkg;
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_P      = 8'h4D;
    localparam logic [7:0] SC_LARROW = 8'h6B;
    localparam logic [7:0] SC_RARROW = 8'h74;
    localparam logic [7:0] SC_OVR0   = 8'h00;
    localparam logic [7:0] SC_OVRF   = 8'hFF;
endpackage

// File: rtl/kbd_game_ctrl.sv
// kbd_game_ctrl: turns a PS/2 scancode byte stream into Space Invaders controls.
//   axis_aclk_i/axis_aresetn_i : clock, async active-low reset
//   s_axis_*                   : scancode byte stream (always ready out of reset)
//   left_o/right_o/fire_o      : held levels (left/right merge letter and arrow keys)
//   fire_pulse_o               : one cycle on a fresh space press
//   pause_o                    : toggles on each fresh P press
//   seq_err_o                  : one cycle on prefix timeout or overrun code
module kbd_game_ctrl
    import kbd_pkg::*;
#(
    parameter int PREFIX_TIMEOUT  = 500000,
    parameter int AXIS_DATA_WIDTH = 8
) (
    input  logic                       axis_aclk_i,
    input  logic                       axis_aresetn_i,
    input  logic                       s_axis_tvalid_i,
    output logic                       s_axis_tready_o,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
    output logic                       left_o,
    output logic                       right_o,
    output logic                       fire_o,
    output logic                       fire_pulse_o,
    output logic                       pause_o,
    output logic                       seq_err_o
);
    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LOAD = TW'(PREFIX_TIMEOUT);

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          ready;
    logic          a_h, d_h, la_h, ra_h, sp_h, p_h, pause, fire_p, err;
    logic          a_n, d_n, la_n, ra_n, sp_n, p_n, pause_n, fire_p_n, err_n;
    logic          hs;
    logic [7:0]    code;

    assign hs   = s_axis_tvalid_i & ready;
    assign code = s_axis_tdata_i[7:0];

    always_comb begin
        state_n  = state;
        timer_n  = (timer != '0) ? timer - 1'b1 : '0;
        a_n      = a_h;
        d_n      = d_h;
        la_n     = la_h;
        ra_n     = ra_h;
        sp_n     = sp_h;
        p_n      = p_h;
        pause_n  = pause;
        fire_p_n = 1'b0;
        err_n    = 1'b0;
        if (hs) begin
            case (state)
                IDLE: begin
                    if (code == SC_EXT) state_n = EXT;
                    else if (code == SC_BRK) state_n = BRK;
                    else if (code == SC_OVR0 || code == SC_OVRF) begin
                        // keyboard buffer overrun: held state can no longer be trusted
                        {a_n, d_n, la_n, ra_n, sp_n, p_n} = '0;
                        err_n = 1'b1;
                    end else begin
                        if (code == SC_A) a_n = 1'b1;
                        if (code == SC_D) d_n = 1'b1;
                        if (code == SC_SPACE) begin
                            sp_n     = 1'b1;
                            fire_p_n = ~sp_h;
                        end
                        if (code == SC_P) begin
                            p_n     = 1'b1;
                            pause_n = pause ^ ~p_h;
                        end
                    end
                end
                EXT: begin
                    state_n = (code == SC_BRK) ? EXT_BRK : IDLE;
                    if (code == SC_LARROW) la_n = 1'b1;
                    if (code == SC_RARROW) ra_n = 1'b1;
                end
                BRK: begin
                    state_n = IDLE;
                    if (code == SC_A) a_n = 1'b0;
                    if (code == SC_D) d_n = 1'b0;
                    if (code == SC_SPACE) sp_n = 1'b0;
                    if (code == SC_P) p_n = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    if (code == SC_LARROW) la_n = 1'b0;
                    if (code == SC_RARROW) ra_n = 1'b0;
                end
            endcase
            // a handshake only leaves IDLE-or-stays-in-prefix when entering a new prefix state
            if (state_n != IDLE) timer_n = T_LOAD;
        end else if (state != IDLE && timer == '0) begin
            state_n = IDLE;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            state  <= IDLE;
            timer  <= '0;
            ready  <= 1'b0;
            a_h    <= 1'b0;
            d_h    <= 1'b0;
            la_h   <= 1'b0;
            ra_h   <= 1'b0;
            sp_h   <= 1'b0;
            p_h    <= 1'b0;
            pause  <= 1'b0;
            fire_p <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            ready  <= 1'b1;
            a_h    <= a_n;
            d_h    <= d_n;
            la_h   <= la_n;
            ra_h   <= ra_n;
            sp_h   <= sp_n;
            p_h    <= p_n;
            pause  <= pause_n;
            fire_p <= fire_p_n;
            err    <= err_n;
        end
    end

    assign s_axis_tready_o = ready;
    assign left_o          = a_h | la_h;
    assign right_o         = d_h | ra_h;
    assign fire_o          = sp_h;
    assign fire_pulse_o    = fire_p;
    assign pause_o         = pause;
    assign seq_err_o       = err;
endmodule

// File: tb/tb_kbd_game_ctrl.sv
// tb_kbd_game_ctrl: directed test-plan sequences plus randomized byte traffic against a key-state model.
module tb_kbd_game_ctrl;
    localparam int T = 12;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready, left, right, fire, fire_pulse, pause, seq_err;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: which physical keys are down, plus pending-prefix bookkeeping
    bit m_ready, m_a, m_d, m_la, m_ra, m_sp, m_p, m_pause, m_fp, m_err;
    bit in_pfx, pfx_ext, pfx_brk;
    int age;

    kbd_game_ctrl #(.PREFIX_TIMEOUT(T), .AXIS_DATA_WIDTH(8)) dut (
        .axis_aclk_i    (clk),
        .axis_aresetn_i (rst_n),
        .s_axis_tvalid_i(valid),
        .s_axis_tready_o(ready),
        .s_axis_tdata_i (data),
        .left_o         (left),
        .right_o        (right),
        .fire_o         (fire),
        .fire_pulse_o   (fire_pulse),
        .pause_o        (pause),
        .seq_err_o      (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] dut_vec();
        return {ready, left, right, fire, fire_pulse, pause, seq_err};
    endfunction

    function automatic logic [6:0] model_vec();
        return {m_ready, m_a | m_la, m_d | m_ra, m_sp, m_fp, m_pause, m_err};
    endfunction

    task automatic model_reset();
        {m_ready, m_a, m_d, m_la, m_ra, m_sp, m_p, m_pause, m_fp, m_err} = '0;
        {in_pfx, pfx_ext, pfx_brk} = '0;
        age = 0;
    endtask

    task automatic press(input logic [7:0] d, input bit ext);
        if (ext) begin
            if (d == 8'h6B) m_la = 1;
            if (d == 8'h74) m_ra = 1;
        end else begin
            if (d == 8'h1C) m_a = 1;
            if (d == 8'h23) m_d = 1;
            if (d == 8'h29) begin
                if (!m_sp) m_fp = 1;
                m_sp = 1;
            end
            if (d == 8'h4D) begin
                if (!m_p) m_pause = !m_pause;
                m_p = 1;
            end
        end
    endtask

    task automatic release_key(input logic [7:0] d, input bit ext);
        if (ext) begin
            if (d == 8'h6B) m_la = 0;
            if (d == 8'h74) m_ra = 0;
        end else begin
            if (d == 8'h1C) m_a = 0;
            if (d == 8'h23) m_d = 0;
            if (d == 8'h29) m_sp = 0;
            if (d == 8'h4D) m_p = 0;
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] d);
        m_fp  = 0;
        m_err = 0;
        if (v && m_ready) begin
            if (!in_pfx) begin
                if (d == 8'hE0) begin
                    in_pfx = 1; pfx_ext = 1; pfx_brk = 0; age = 0;
                end else if (d == 8'hF0) begin
                    in_pfx = 1; pfx_ext = 0; pfx_brk = 1; age = 0;
                end else if (d == 8'h00 || d == 8'hFF) begin
                    {m_a, m_d, m_la, m_ra, m_sp, m_p} = '0;
                    m_err = 1;
                end else press(d, 0);
            end else if (pfx_ext && !pfx_brk && d == 8'hF0) begin
                pfx_brk = 1;
                age = 0;
            end else begin
                in_pfx = 0;
                if (pfx_brk) release_key(d, pfx_ext);
                else press(d, pfx_ext);
            end
        end else if (in_pfx) begin
            // the next byte may arrive up to T idle cycles after the prefix
            age++;
            if (age > T) begin
                in_pfx = 0;
                m_err = 1;
            end
        end
        m_ready = 1;
    endtask

    task automatic cycle(input bit v, input logic [7:0] d);
        @(negedge clk);
        valid = v;
        data  = d;
        @(posedge clk);
        model_step(v, d);
        #1 check("outs", {25'd0, dut_vec()}, {25'd0, model_vec()});
    endtask

    task automatic send(input logic [7:0] d);
        cycle(1, d);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 8'h00);
    endtask

    task automatic reset_for(input int n);
        @(negedge clk);
        rst_n = 0;
        valid = 0;
        model_reset();
        #1 check("rst_async", {25'd0, dut_vec()}, 32'd0);
        repeat (n) @(posedge clk);
        #1 check("rst_hold", {25'd0, dut_vec()}, 32'd0);
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic [7:0] pick();
        logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h1C, 8'h23, 8'h29, 8'h4D, 8'h6B,
                                  8'h74, 8'h00, 8'hFF, 8'hFA, 8'hAA, 8'hE1, 8'h12};
        int r = $urandom_range(0, 16);
        return (r < 14) ? pool[r] : 8'($urandom);
    endfunction

    initial begin
        reset_for(2);
        idle(1);
        check("ready_up", {31'd0, ready}, 32'd1);

        // fire: pulse once, typematic repeats silent, break clears
        send(8'h29);
        check("fire_pulse", {31'd0, fire_pulse}, 32'd1);
        idle(1);
        check("fire_pulse_1cyc", {31'd0, fire_pulse}, 32'd0);
        send(8'h29); send(8'h29); send(8'h29);
        check("fire_repeat", {31'd0, fire_pulse}, 32'd0);
        send(8'hF0); send(8'h29); idle(1);
        check("fire_release", {31'd0, fire}, 32'd0);

        // left from two sources
        send(8'hE0); send(8'h6B); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h6B); idle(1);
        check("left_other_src", {31'd0, left}, 32'd1);
        send(8'hF0); send(8'h1C); idle(1);
        check("left_clear", {31'd0, left}, 32'd0);

        // pause toggles only on fresh presses
        send(8'h4D);
        check("pause_on", {31'd0, pause}, 32'd1);
        send(8'h4D); send(8'hF0); send(8'h4D); send(8'h4D); idle(1);
        check("pause_off", {31'd0, pause}, 32'd0);

        // prefix timeout then a normal byte
        send(8'hF0); idle(T);
        check("no_err_early", {31'd0, seq_err}, 32'd0);
        idle(1);
        check("timeout_err", {31'd0, seq_err}, 32'd1);
        send(8'h23); idle(1);
        check("right_after_to", {31'd0, right}, 32'd1);

        // byte on the expiry cycle wins: it's a break of D
        send(8'hF0); idle(T); send(8'h23);
        check("expiry_hs_noerr", {31'd0, seq_err}, 32'd0);
        check("expiry_hs_brk", {31'd0, right}, 32'd0);

        // overrun clears held keys
        send(8'h23); send(8'h29); send(8'hFF);
        check("ovr_err", {31'd0, seq_err}, 32'd1);
        check("ovr_clear", {30'd0, right, fire}, 32'd0);
        idle(1);

        // reset mid-sequence drops the prefix
        send(8'hE0);
        reset_for(2);
        idle(1);
        send(8'h74); idle(1);
        check("rst_mid_seq", {31'd0, right}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 4) idle($urandom_range(T - 1, T + 2));
            else if (r == 4) begin
                reset_for($urandom_range(1, 3));
                idle(1);
            end else cycle($urandom_range(0, 3) != 0, pick());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/kbd_game_ctrl.md
# kbd_game_ctrl

Consumes the PS/2 scancode AXI stream produced by the keyboard front-end and sequences it into game controls for Space Invaders. Tracks prefix bytes (E0 extended, F0 break), keeps press/release state for mapped keys, suppresses typematic repeats, and emits held levels plus one-cycle action pulses. Sits between the keyboard stream source and the game logic at top level.

## Interface
- PREFIX_TIMEOUT, 500000: cycles allowed between a prefix byte and the next byte before the sequence is abandoned (10 ms at 50 MHz); must be ≥ 1.
- AXIS_DATA_WIDTH, 8: stream data width; only bits [7:0] are decoded.

- axis_aclk_i  in  1  single clock for all logic.
- axis_aresetn_i  in  1  reset; one clock; reset is asynchronous and active-low.
- s_axis_tvalid_i  in  1  scancode byte valid.
- s_axis_tready_o  out  1  ready; 0 in reset, 1 otherwise.
- s_axis_tdata_i  in  AXIS_DATA_WIDTH  scancode byte.
- left_o  out  1  level, left held (A or E0 6B).
- right_o  out  1  level, right held (D or E0 74).
- fire_o  out  1  level, space (29) held.
- fire_pulse_o  out  1  one-cycle pulse on a new space press.
- pause_o  out  1  level, toggles on each new P (4D) press.
- seq_err_o  out  1  one-cycle pulse on prefix timeout or overrun code (00/FF).

## Operation
- Byte accepted when s_axis_tvalid_i & s_axis_tready_o; no backpressure after reset.
- FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 -> EXT; F0 -> BRK; 00/FF -> clear held keys, seq_err pulse, stay; mapped make -> set key; other -> ignore.
  - EXT: F0 -> EXT_BRK; 6B/74 make -> set left/right, -> IDLE; other -> IDLE, ignored.
  - BRK: mapped code -> clear key, -> IDLE; other -> IDLE.
  - EXT_BRK: 6B/74 -> clear left/right, -> IDLE; other -> IDLE.
- Left held = A_held | LARROW_held (separate internal bits); same for right. Release of one source does not clear the other.
- Make of an already-held key (typematic repeat): no pulse, no pause toggle.
- Left and right both held: both outputs 1; arbitration belongs to game logic.
- FA, AA, E1 and unmapped codes ignored in IDLE; E1 pause-key sequence decodes to nothing.
- Prefix timer: loaded with PREFIX_TIMEOUT on entry to EXT/BRK/EXT_BRK; decrements each cycle without handshake; at 0 -> IDLE, seq_err pulse, held keys kept. A handshake in the same cycle as expiry wins (byte decoded normally, no error).
- Timer width $clog2(PREFIX_TIMEOUT+1), unsigned, saturates at 0.

## Timing
- Reset: state IDLE, all held bits 0, all outputs 0, pause_o 0, timer 0, s_axis_tready_o 0.
- Latency: outputs change on the clock edge after the accepting handshake (1 cycle registered).
- fire_pulse_o, seq_err_o high exactly one cycle.
- Back-to-back bytes every cycle supported.
- Reset mid-sequence (e.g. after E0): returns to IDLE; next byte decoded as unprefixed.

## Structure
- Shared package kbd_pkg: state_t enum (IDLE, EXT, BRK, EXT_BRK); scancode constants SC_EXT=E0, SC_BRK=F0, SC_A=1C, SC_D=23, SC_SPACE=29, SC_P=4D, SC_LARROW=6B, SC_RARROW=74, SC_OVR0=00, SC_OVRF=FF.
- No sub-module; timer inline. Instantiated beside the keyboard stream source at top level, connected master to slave.

## Test plan
- Send 29 -> fire_o=1, fire_pulse_o one cycle; send 29 ×3 -> no further pulse; send F0 29 -> fire_o=0.
- Send E0 6B, then 1C, then E0 F0 6B -> left_o stays 1; then F0 1C -> left_o=0.
- Send 4D, 4D (repeat), F0 4D, 4D -> pause_o 1 then 0 (two toggles only).
- Send F0 then idle PREFIX_TIMEOUT cycles -> seq_err_o pulse, state IDLE; next 23 sets right_o=1.
- Hold 23 and 29, send FF -> right_o=fire_o=0, seq_err_o pulse.
- Send E0, assert axis_aresetn_i=0 for 2 cycles, release, send 74 -> right_o stays 0 (unmapped without prefix).
